// File: rtl/div_iter_radix2.sv
// Restoring radix-2 iterative divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow resolve at accept.
module div_iter_radix2 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_flush,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_ready,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [1:0]       op_q;
  logic             sign_a_q, sign_b_q;
  logic [WIDTH-1:0] quo_q, dvs_q, rem_q, result_q;
  logic             valid_q, ready_q, busy_q;

  logic             accept_c, special_c, is_signed_c, sign_a_c, sign_b_c;
  logic             div0_c, ovf_c, ge_c, fix_signed_c;
  logic [WIDTH-1:0] abs_a_c, abs_b_c, special_res_c, q_fix_c, r_fix_c, fix_res_c;
  logic [WIDTH:0]   rem_s_c, trial_c;

  // Operand conditioning and special-case detection on the incoming request
  always_comb begin
    is_signed_c   = ~i_op[0];
    sign_a_c      = is_signed_c & i_dividend[WIDTH-1];
    sign_b_c      = is_signed_c & i_divisor[WIDTH-1];
    abs_a_c       = sign_a_c ? (~i_dividend + WIDTH'(1)) : i_dividend;
    abs_b_c       = sign_b_c ? (~i_divisor + WIDTH'(1)) : i_divisor;
    div0_c        = (i_divisor == '0);
    ovf_c         = is_signed_c & (i_dividend == MIN_VAL) & (i_divisor == '1);
    special_c     = div0_c | ovf_c;
    special_res_c = '0;
    if (div0_c) special_res_c = i_op[1] ? i_dividend : '1;
    else        special_res_c = i_op[1] ? '0 : MIN_VAL;
  end

  // One restoring iteration plus final sign fix-up
  always_comb begin
    rem_s_c      = {rem_q, quo_q[WIDTH-1]};
    trial_c      = rem_s_c - {1'b0, dvs_q};
    ge_c         = ~trial_c[WIDTH];
    fix_signed_c = ~op_q[0];
    q_fix_c      = (fix_signed_c & (sign_a_q ^ sign_b_q)) ? (~quo_q + WIDTH'(1)) : quo_q;
    r_fix_c      = (fix_signed_c & sign_a_q) ? (~rem_q + WIDTH'(1)) : rem_q;
    fix_res_c    = op_q[1] ? r_fix_c : q_fix_c;
  end

  // Next-state logic; flush overrides everything including a same-cycle start
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    if (i_flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (i_start) begin
          accept_c = 1'b1;
          state_d  = special_c ? S_DONE : S_CALC;
        end
        S_CALC: if (cnt_q == '0) state_d = S_FIX;
        S_FIX:  state_d = S_DONE;
        S_DONE: if (i_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State register with registered handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d == S_DONE);
      ready_q <= (state_d == S_IDLE);
      busy_q  <= (state_d != S_IDLE);
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      quo_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else if (accept_c) begin
      op_q     <= i_op;
      sign_a_q <= sign_a_c;
      sign_b_q <= sign_b_c;
      quo_q    <= abs_a_c;
      dvs_q    <= abs_b_c;
      rem_q    <= '0;
      cnt_q    <= CW'(WIDTH - 1);
      if (special_c) result_q <= special_res_c;
    end else if (state_q == S_CALC) begin
      quo_q <= {quo_q[WIDTH-2:0], ge_c};
      rem_q <= ge_c ? trial_c[WIDTH-1:0] : rem_s_c[WIDTH-1:0];
      cnt_q <= cnt_q - CW'(1);
    end else if ((state_q == S_FIX) && !i_flush) begin
      result_q <= fix_res_c;
    end
  end

  assign o_ready  = ready_q;
  assign o_busy   = busy_q;
  assign o_valid  = valid_q;
  assign o_result = result_q;

endmodule
